// File: rtl/mips_pkg.sv
// Shared constants, fetch state encoding and PC range helper for the MIPS front end.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package mips_pkg;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0040_0000;

    // Opcode field of an instruction word, consumed by the control decoder.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE,
        HALT
    } fetchState_e;

    // True when pc lies in [base, base + 4*depth). Subtracting first keeps the
    // test to one unsigned compare; the window itself never wraps 2^32.
    function automatic logic pcInRange(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input int unsigned depth);
        logic [31:0] offset;
        offset = pc - base;
        return offset < 32'(depth * 4);
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump over taken branch over sequential.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is consumed.
module next_pc_logic (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic        jump,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic        branchTaken;
    logic [31:0] branchAddr;
    logic [31:0] jumpAddr;

    assign branchTaken = (branch_eq & zero) | (branch_ne & ~zero);
    assign branchAddr  = pc_plus4 + (branch_offset << 2);
    assign jumpAddr    = {pc_plus4[31:28], jump_target, 2'b00};

    // Priority select; jump overrides any simultaneous branch condition.
    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        if (jump) begin
            next_pc  = jumpAddr;
            redirect = 1'b1;
        end else if (branchTaken) begin
            next_pc  = branchAddr;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, request/ready fetch FSM and hold register toward decode.
// Latency: 2 cycles per instruction minimum (1 in REQ, 1 in ISSUE); memory wait states add 1 each.
// Backpressure: stall holds the issued instruction and blocks the next fetch; imem_ready gates REQ.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET     = PC_RESET_DEFAULT,
    parameter int unsigned MEMORY_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        zero,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        fault
);

    fetchState_e state;
    logic [31:0] pc;
    logic [31:0] nextPc;
    logic        redirect;
    logic [31:0] issuePc;
    logic        issueLegal;
    logic        pcLegal;

    next_pc_logic u_next_pc (
        .pc_plus4      (pc_plus4),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .jump          (jump),
        .branch_eq     (branch_eq),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .next_pc       (nextPc),
        .redirect      (redirect)
    );

    // pc already holds pc_plus4 while in ISSUE, so only a redirect replaces it.
    assign issuePc    = redirect ? nextPc : pc;
    assign issueLegal = pcInRange(issuePc, PC_RESET, MEMORY_DEPTH);
    assign pcLegal    = pcInRange(pc, PC_RESET, MEMORY_DEPTH);
    assign imem_addr  = pc;

    // Fetch FSM with registered outputs; every entry to REQ is range-checked first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= PC_RESET;
            instr       <= NOP_WORD;
            pc_plus4    <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fault       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pcLegal) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else begin
                        state <= HALT;
                        fault <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        pc_plus4    <= pc + 32'd4;
                        pc          <= pc + 32'd4;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        pc          <= issuePc;
                        if (issueLegal) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= HALT;
                            fault <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front end of the MIPS datapath. It produces the instruction word whose opcode field [31:26] drives the control decoder. It consumes that decoder's branch and jump outputs to redirect the PC.
Multi-cycle fetch over a request/ready handshake to instruction memory, with a hold register toward decode and a stall input from downstream.

Parameters:
PC_RESET, 32'h0040_0000, PC value loaded on reset (MARS text base).
MEMORY_DEPTH, 64, instruction memory size in words; legal PCs are PC_RESET to PC_RESET+4*MEMORY_DEPTH-4.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  byte address of the fetch, equal to the current PC.
imem_ready  in  1  memory indicates imem_rdata is valid this cycle.
imem_rdata  in  32  instruction word from memory.
stall  in  1  downstream cannot accept the held instruction.
branch_eq  in  1  BranchEQ from the control decoder.
branch_ne  in  1  BranchNE from the control decoder.
jump  in  1  Jump from the control decoder.
zero  in  1  ALU zero flag for the held instruction.
branch_offset  in  32  sign-extended 16-bit immediate of the held instruction.
jump_target  in  26  instr[25:0] of the held instruction.
instr  out  32  held instruction word; [31:26] feeds the decoder OP.
pc_plus4  out  32  address of the held instruction plus 4 (for jal link and branch base).
instr_valid  out  1  instr holds a fetched instruction.
fault  out  1  sticky flag: PC left the legal range.

Behaviour:
- Reset (asynchronous, immediate):
  - pc=PC_RESET, instr=32'h0 (nop), pc_plus4=32'h0, instr_valid=0, imem_req=0, fault=0, state=IDLE.
  - Reset asserted mid-handshake abandons the request; imem_req drops without waiting for imem_ready.
- States: IDLE, REQ, ISSUE, HALT.
- IDLE: imem_req=0. Next state is REQ (one dead cycle after reset release).
- REQ:
  - Outputs: imem_req=1, imem_addr=pc. instr_valid is 0 in this state.
  - req and addr stay stable until imem_ready is sampled high. There is no timeout.
  - On the edge where imem_ready=1: instr<=imem_rdata, pc_plus4<=pc+4, pc<=pc+4, instr_valid<=1, state<=ISSUE.
  - Minimum latency is 1 cycle in REQ plus 1 cycle in ISSUE, i.e. 2 cycles per instruction.
- ISSUE:
  - Outputs: imem_req=0, instr_valid=1.
  - stall=1: hold all state; branch and jump inputs are ignored.
  - stall=0: the instruction is consumed this edge and the state returns to REQ with the PC selected below.
- PC selection (ISSUE, stall=0), in priority order:
  - jump=1: pc <= {pc_plus4[31:28], jump_target, 2'b00}. Jump wins over any branch.
  - (branch_eq & zero) | (branch_ne & ~zero): pc <= pc_plus4 + (branch_offset<<2).
  - Otherwise: pc keeps pc_plus4 (already advanced).
  - branch_eq and branch_ne both high is evaluated by the OR above.
- Arithmetic: all additions are modulo 2^32 with no saturation. Targets are always word-aligned by construction.
- Range check, on entry to REQ:
  - Legal: PC_RESET <= pc < PC_RESET+4*MEMORY_DEPTH.
  - Out of range: no request is issued; fault<=1, state<=HALT, instr_valid=0.
- HALT: absorbing state. imem_req=0, fault=1. Only reset exits.
- The sequential register update is a single always block with asynchronous reset. Next-PC logic is combinational.

Decomposition:
- Shared package `mips_pkg`:
  - constants: NOP_WORD, PC_RESET_DEFAULT, opcode field slice positions;
  - typedef for the fetch state enum (IDLE/REQ/ISSUE/HALT).
- One natural sub-module, `next_pc_logic`: combinational; inputs pc_plus4, branch_offset, jump_target, jump, branch_eq, branch_ne, zero; outputs next_pc and redirect.

Test Plan:
1. Reset sequence: assert reset mid-cycle -> outputs go to reset values immediately (instr_valid=0, imem_req=0, fault=0). Release -> IDLE for 1 cycle, then imem_req=1 with imem_addr=0x00400000.
2. Zero-wait fetch: imem_ready tied 1, rdata=0x20080005 -> instr=0x20080005 with instr_valid=1 the next cycle, pc_plus4=0x00400004. Next request at 0x00400004, 2 cycles later.
3. Wait states and stall:
   - ready held low 3 cycles -> imem_req and imem_addr stable all 3 cycles.
   - stall=1 for 2 cycles in ISSUE -> instr unchanged, no new request.
4. BEQ taken: held instruction at 0x00400008, branch_eq=1, zero=1, offset=0xFFFFFFFD -> next imem_addr=0x00400000.
   BNE not taken: branch_ne=1, zero=1 -> next imem_addr=0x0040000C.
5. Jump priority: jump=1, jump_target=26'h0100003, branch_eq=1, zero=1 simultaneously -> next imem_addr=0x0040000C (jump wins).
6. Range fault: jump to target 0x00400100 with MEMORY_DEPTH=64 -> no request issued, fault=1, state HALT persists until reset.
